imm_extend_pipe: RTL and testbench

Parametrised, pipelined successor to the decode-stage immediate extender. It decodes the immediate of an instruction word for the I, S, B, J and U formats, and optionally the CSR zimm format. The result is sign-extended to XLEN and moved through STAGES elastic register stages with valid/ready handshakes, flush and a sideband tag. It sits between fetch/decode and the ID/EX boundary, so immediate generation can be retimed without changing the decoder.

---
 rtl/imm_extend_pipe_if.sv | 34 +++
 rtl/imm_extend_pipe.sv | 141 ++++++++++++++
 tb/tb_imm_extend_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - handshake bundle for imm_extend_pipe
//
// Purpose: groups the producer-side and consumer-side handshakes of the
// immediate-extension pipeline.
// Ports (signals):
//   in_valid/in_ready/in_instr[31:0]/in_sel[2:0]/in_tag[TAG_W-1:0]   producer side
//   out_valid/out_ready/out_imm[XLEN-1:0]/out_tag[TAG_W-1:0]/out_err consumer side
// Modports: master = the environment driving instructions and accepting results,
//           slave  = the pipeline itself.
interface imm_extend_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_instr, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_instr, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined RISC-V immediate decoder/extender
//
// Purpose: decodes the I/S/B/J/U (and optionally CSR zimm) immediate of an
// instruction word, sign-extends it to XLEN and carries it with a sideband tag
// through STAGES elastic valid/ready register stages.
// Parameters: XLEN (32|64), STAGES (1..4), TAG_W.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   flush  synchronous kill of all in-flight entries
//   bus    imm_extend_pipe_if.slave (in_* producer side, out_* consumer side)
// Build option: define IMM_EXT_ZIMM_EN to decode in_sel=5 as zero-extended
// instr[19:15]; without it in_sel=5 is reported as an illegal selector.
module imm_extend_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    imm_extend_pipe_if.slave bus
);
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
`ifdef IMM_EXT_ZIMM_EN
    localparam logic [2:0] IMM_Z = 3'd5;
`endif

    logic [31:0]     instr;
    logic [31:0]     imm32;
    logic            dec_err;
    logic [XLEN-1:0] dec_imm;
    logic            unused_opcode;

    assign instr         = bus.in_instr;
    assign unused_opcode = ^instr[6:0];

    // Every format is first built as a 32-bit value whose bit 31 is the
    // desired extension bit, so widening to XLEN is a single signed cast.
    always_comb begin
        imm32   = '0;
        dec_err = 1'b0;
        case (bus.in_sel)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
`ifdef IMM_EXT_ZIMM_EN
            IMM_Z: imm32 = {27'b0, instr[19:15]};
`endif
            default: dec_err = 1'b1;
        endcase
    end

    assign dec_imm = XLEN'($signed(imm32));

    // Pipeline state
    logic [STAGES-1:0] v;
    logic [XLEN-1:0]   imm_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [STAGES-1:0] err_q;

    // Per-stage source: stage 0 takes the decoder, later stages their predecessor
    logic [XLEN-1:0]   src_imm [STAGES];
    logic [TAG_W-1:0]  src_tag [STAGES];
    logic [STAGES-1:0] src_err;
    logic [STAGES-1:0] src_v;

    for (genvar k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_head
            assign src_v[k]   = bus.in_valid;
            assign src_imm[k] = dec_imm;
            assign src_tag[k] = bus.in_tag;
            assign src_err[k] = dec_err;
        end else begin : g_tail
            assign src_v[k]   = v[k-1];
            assign src_imm[k] = imm_q[k-1];
            assign src_tag[k] = tag_q[k-1];
            assign src_err[k] = err_q[k-1];
        end
    end

    // Ready ripples backwards from out_ready: a stage can take new content
    // when it is empty or its current content leaves this cycle.
    logic [STAGES-1:0] take;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;

    always_comb begin
        logic rdy;
        rdy  = bus.out_ready;
        take = '0;
        adv  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]  = v[k] & rdy;
            take[k] = ~v[k] | (v[k] & rdy);
            rdy     = ~v[k] | (v[k] & rdy);
        end
    end

    assign ld = take & src_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v     <= '0;
            err_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    imm_q[k] <= src_imm[k];
                    tag_q[k] <= src_tag[k];
                    err_q[k] <= src_err[k];
                end
            end
            // Flush wins over any load; a transfer already valid on the output
            // this cycle is still seen by the consumer.
            if (flush) begin
                v <= '0;
            end else begin
                v <= (v & ~adv) | ld;
            end
        end
    end

    assign bus.in_ready  = take[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.out_imm   = imm_q[STAGES-1];
    assign bus.out_tag   = tag_q[STAGES-1];
    assign bus.out_err   = err_q[STAGES-1];
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;
    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.XLEN(32), .TAG_W(32)) ia ();
    imm_extend_pipe_if #(.XLEN(64), .TAG_W(32)) ib ();
    imm_extend_pipe_if #(.XLEN(32), .TAG_W(32)) ic ();

    imm_extend_pipe #(.XLEN(32), .STAGES(1), .TAG_W(32)) u_s1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(ia));
    imm_extend_pipe #(.XLEN(64), .STAGES(3), .TAG_W(32)) u_s3 (
        .clk(clk), .rst(rst), .flush(flush), .bus(ib));
    imm_extend_pipe #(.XLEN(32), .STAGES(2), .TAG_W(32)) u_s2 (
        .clk(clk), .rst(rst), .flush(flush), .bus(ic));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_s1_hs valid=%b ready=%b exp 0/1", ia.out_valid, ia.in_ready);
        end
        checks++;
        if (ia.out_imm !== 32'h0 || ia.out_tag !== 32'h0 || ia.out_err !== 1'b0) begin
            failures++; $display("FAIL reset_s1_data imm=%h tag=%h err=%b exp 0", ia.out_imm, ia.out_tag, ia.out_err);
        end
        checks++;
        if (ib.out_valid !== 1'b0 || ib.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_s3_hs valid=%b ready=%b exp 0/1", ib.out_valid, ib.in_ready);
        end
        checks++;
        if (ib.out_imm !== 64'h0 || ib.out_tag !== 32'h0 || ib.out_err !== 1'b0) begin
            failures++; $display("FAIL reset_s3_data imm=%h tag=%h err=%b exp 0", ib.out_imm, ib.out_tag, ib.out_err);
        end
        checks++;
        if (ic.out_valid !== 1'b0 || ic.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_s2_hs valid=%b ready=%b exp 0/1", ic.out_valid, ic.in_ready);
        end
        checks++;
        if (ic.out_imm !== 32'h0 || ic.out_tag !== 32'h0 || ic.out_err !== 1'b0) begin
            failures++; $display("FAIL reset_s2_data imm=%h tag=%h err=%b exp 0", ic.out_imm, ic.out_tag, ic.out_err);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_i_type_b_type();
        ia.out_ready = 1'b1;
        ia.in_valid  = 1'b1;
        ia.in_sel    = 3'd0;
        ia.in_instr  = 32'hFF700013;   // addi imm=-9
        ia.in_tag    = 32'h100;
        #1;
        checks++;
        if (ia.in_ready !== 1'b1) begin
            failures++; $display("FAIL i_ready got=%b exp=1", ia.in_ready);
        end
        tick();
        ia.in_sel   = 3'd2;
        ia.in_instr = 32'hFE000EE3;    // branch offset -4
        ia.in_tag   = 32'h104;
        checks++;
        if (ia.out_valid !== 1'b1 || ia.out_imm !== 32'hFFFFFFF7 || ia.out_err !== 1'b0 || ia.out_tag !== 32'h100) begin
            failures++; $display("FAIL i_type v=%b imm=%h err=%b tag=%h exp 1/fffffff7/0/100", ia.out_valid, ia.out_imm, ia.out_err, ia.out_tag);
        end
        tick();
        ia.in_valid = 1'b0;
        checks++;
        if (ia.out_valid !== 1'b1 || ia.out_imm !== 32'hFFFFFFFC || ia.out_err !== 1'b0 || ia.out_tag !== 32'h104) begin
            failures++; $display("FAIL b_type v=%b imm=%h err=%b tag=%h exp 1/fffffffc/0/104", ia.out_valid, ia.out_imm, ia.out_err, ia.out_tag);
        end
        tick();
        checks++;
        if (ia.out_valid !== 1'b0) begin
            failures++; $display("FAIL i_b_drain got=%b exp=0", ia.out_valid);
        end
    endtask

    task automatic test_illegal_sel();
        logic [31:0] exp_imm;
        logic        exp_err;
`ifdef IMM_EXT_ZIMM_EN
        exp_imm = 32'h1F;
        exp_err = 1'b0;
`else
        exp_imm = 32'h0;
        exp_err = 1'b1;
`endif
        ia.in_valid = 1'b1;
        ia.in_sel   = 3'd7;
        ia.in_instr = 32'hFF700013;
        ia.in_tag   = 32'h200;
        tick();
        ia.in_sel   = 3'd5;
        ia.in_instr = 32'h000F8073;    // rs1/zimm field = 0x1F
        ia.in_tag   = 32'h204;
        checks++;
        if (ia.out_valid !== 1'b1 || ia.out_err !== 1'b1 || ia.out_imm !== 32'h0 || ia.out_tag !== 32'h200) begin
            failures++; $display("FAIL sel7 v=%b err=%b imm=%h tag=%h exp 1/1/0/200", ia.out_valid, ia.out_err, ia.out_imm, ia.out_tag);
        end
        tick();
        ia.in_valid = 1'b0;
        checks++;
        if (ia.out_valid !== 1'b1 || ia.out_err !== exp_err || ia.out_imm !== exp_imm || ia.out_tag !== 32'h204) begin
            failures++; $display("FAIL sel5 v=%b err=%b imm=%h tag=%h exp err=%b imm=%h", ia.out_valid, ia.out_err, ia.out_imm, ia.out_tag, exp_err, exp_imm);
        end
        tick();
    endtask

    task automatic test_u_j_latency();
        ib.out_ready = 1'b1;
        ib.in_valid  = 1'b1;
        ib.in_sel    = 3'd4;
        ib.in_instr  = 32'h12345037;
        ib.in_tag    = 32'd1;
        tick();
        ib.in_sel   = 3'd3;
        ib.in_instr = 32'h0100006F;    // jal +16
        ib.in_tag   = 32'd2;
        checks++;
        if (ib.out_valid !== 1'b0) begin
            failures++; $display("FAIL u_early1 valid=%b exp=0", ib.out_valid);
        end
        tick();
        ib.in_valid = 1'b0;
        checks++;
        if (ib.out_valid !== 1'b0) begin
            failures++; $display("FAIL u_early2 valid=%b exp=0", ib.out_valid);
        end
        tick();
        checks++;
        if (ib.out_valid !== 1'b1 || ib.out_imm !== 64'h0000000012345000 || ib.out_err !== 1'b0 || ib.out_tag !== 32'd1) begin
            failures++; $display("FAIL u_type v=%b imm=%h err=%b tag=%h exp 1/12345000/0/1", ib.out_valid, ib.out_imm, ib.out_err, ib.out_tag);
        end
        tick();
        checks++;
        if (ib.out_valid !== 1'b1 || ib.out_imm !== 64'h10 || ib.out_err !== 1'b0 || ib.out_tag !== 32'd2) begin
            failures++; $display("FAIL j_type v=%b imm=%h err=%b tag=%h exp 1/10/0/2", ib.out_valid, ib.out_imm, ib.out_err, ib.out_tag);
        end
        tick();
        checks++;
        if (ib.out_valid !== 1'b0) begin
            failures++; $display("FAIL u_j_drain valid=%b exp=0", ib.out_valid);
        end
    endtask

    task automatic test_sign_ext();
        ib.out_ready = 1'b1;
        ib.in_valid  = 1'b1;
        ib.in_sel    = 3'd4;
        ib.in_instr  = 32'h80000037;
        ib.in_tag    = 32'd3;
        tick();
        ib.in_sel   = 3'd1;
        ib.in_instr = 32'h04000A23;    // store offset +84
        ib.in_tag   = 32'd4;
        tick();
        ib.in_valid = 1'b0;
        tick();
        checks++;
        if (ib.out_valid !== 1'b1 || ib.out_imm !== 64'hFFFFFFFF80000000 || ib.out_tag !== 32'd3) begin
            failures++; $display("FAIL u_sext v=%b imm=%h tag=%h exp 1/ffffffff80000000/3", ib.out_valid, ib.out_imm, ib.out_tag);
        end
        tick();
        checks++;
        if (ib.out_valid !== 1'b1 || ib.out_imm !== 64'h0000000000000054 || ib.out_tag !== 32'd4) begin
            failures++; $display("FAIL s_type v=%b imm=%h tag=%h exp 1/54/4", ib.out_valid, ib.out_imm, ib.out_tag);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int          nxt;
        int          got_n;
        logic [31:0] got [4];
        ic.out_ready = 1'b0;
        ic.in_valid  = 1'b1;
        ic.in_sel    = 3'd0;
        for (int i = 1; i <= 2; i++) begin
            ic.in_instr = (32'(i) << 20) | 32'h13;
            ic.in_tag   = 32'(i);
            #1;
            checks++;
            if (ic.in_ready !== 1'b1) begin
                failures++; $display("FAIL bp_accept%0d ready=%b exp=1", i, ic.in_ready);
            end
            tick();
        end
        ic.in_instr = (32'd3 << 20) | 32'h13;
        ic.in_tag   = 32'd3;
        #1;
        checks++;
        if (ic.in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_full ready=%b exp=0", ic.in_ready);
        end
        tick();
        checks++;
        if (ic.in_ready !== 1'b0 || ic.out_valid !== 1'b1 || ic.out_imm !== 32'd1) begin
            failures++; $display("FAIL bp_hold ready=%b v=%b imm=%h exp 0/1/1", ic.in_ready, ic.out_valid, ic.out_imm);
        end
        ic.out_ready = 1'b1;
        #1;
        checks++;
        if (ic.in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_no_bubble ready=%b exp=1", ic.in_ready);
        end
        nxt   = 3;
        got_n = 0;
        for (int cyc = 0; cyc < 20 && got_n < 4; cyc++) begin
            ic.in_valid = (nxt <= 4);
            ic.in_instr = (32'(nxt) << 20) | 32'h13;
            ic.in_tag   = 32'(nxt);
            #1;
            if (ic.out_valid === 1'b1) begin
                if (got_n < 4) got[got_n] = ic.out_imm;
                got_n++;
            end
            if (ic.in_valid && ic.in_ready === 1'b1) nxt++;
            tick();
        end
        ic.in_valid = 1'b0;
        checks++;
        if (got_n != 4 || nxt != 5) begin
            failures++; $display("FAIL bp_count got=%0d accepted_next=%0d exp 4/5", got_n, nxt);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k < got_n && got[k] !== 32'(k + 1)) begin
                failures++; $display("FAIL bp_order%0d got=%h exp=%h", k, got[k], 32'(k + 1));
            end else if (k >= got_n) begin
                failures++; $display("FAIL bp_order%0d got=missing exp=%h", k, 32'(k + 1));
            end
        end
        checks++;
        if (ic.out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_no_dup valid=%b exp=0", ic.out_valid);
        end
    endtask

    task automatic test_flush();
        ib.out_ready = 1'b0;
        ib.in_valid  = 1'b1;
        ib.in_sel    = 3'd0;
        for (int i = 1; i <= 3; i++) begin
            ib.in_instr = (32'(i) << 20) | 32'h13;
            ib.in_tag   = 32'(10 + i);
            tick();
        end
        checks++;
        if (ib.in_ready !== 1'b0 || ib.out_valid !== 1'b1 || ib.out_imm !== 64'd1 || ib.out_tag !== 32'd11) begin
            failures++; $display("FAIL flush_fill ready=%b v=%b imm=%h tag=%h exp 0/1/1/11", ib.in_ready, ib.out_valid, ib.out_imm, ib.out_tag);
        end
        flush        = 1'b1;
        ib.out_ready = 1'b1;
        ib.in_instr  = (32'd9 << 20) | 32'h13;
        ib.in_tag    = 32'd99;
        #1;
        checks++;
        if (ib.in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_ready ready=%b exp=1", ib.in_ready);
        end
        tick();
        flush       = 1'b0;
        ib.in_valid = 1'b0;
        checks++;
        if (ib.out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_clear valid=%b exp=0", ib.out_valid);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (ib.out_valid !== 1'b0) begin
                failures++; $display("FAIL flush_drop%0d valid=%b exp=0", c, ib.out_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        ib.out_ready = 1'b0;
        ib.in_valid  = 1'b1;
        ib.in_sel    = 3'd0;
        for (int i = 5; i <= 7; i++) begin
            ib.in_instr = (32'(i) << 20) | 32'h13;
            ib.in_tag   = 32'(i);
            tick();
        end
        ib.in_valid = 1'b0;
        checks++;
        if (ib.out_valid !== 1'b1 || ib.out_imm !== 64'd5) begin
            failures++; $display("FAIL rst_fill v=%b imm=%h exp 1/5", ib.out_valid, ib.out_imm);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ib.out_valid !== 1'b0 || ib.in_ready !== 1'b1 || ib.out_imm !== 64'h0 || ib.out_tag !== 32'h0 || ib.out_err !== 1'b0) begin
            failures++; $display("FAIL rst_async v=%b ready=%b imm=%h tag=%h err=%b exp 0/1/0/0/0", ib.out_valid, ib.in_ready, ib.out_imm, ib.out_tag, ib.out_err);
        end
        #2 rst = 1'b0;
        ib.out_ready = 1'b1;
        ib.in_valid  = 1'b1;
        ib.in_instr  = 32'hFF700013;
        ib.in_tag    = 32'h55;
        tick();
        ib.in_valid = 1'b0;
        tick();
        checks++;
        if (ib.out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_first_early valid=%b exp=0", ib.out_valid);
        end
        tick();
        checks++;
        if (ib.out_valid !== 1'b1 || ib.out_imm !== 64'hFFFFFFFFFFFFFFF7 || ib.out_tag !== 32'h55) begin
            failures++; $display("FAIL rst_first v=%b imm=%h tag=%h exp 1/fffffffffffffff7/55", ib.out_valid, ib.out_imm, ib.out_tag);
        end
        tick();
    endtask

    initial begin
        ia.in_valid = 1'b0; ia.in_instr = '0; ia.in_sel = '0; ia.in_tag = '0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_instr = '0; ib.in_sel = '0; ib.in_tag = '0; ib.out_ready = 1'b0;
        ic.in_valid = 1'b0; ic.in_instr = '0; ic.in_sel = '0; ic.in_tag = '0; ic.out_ready = 1'b0;
        test_reset();
        test_i_type_b_type();
        test_illegal_sel();
        test_u_j_latency();
        test_sign_ext();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
